gray_code_counter: RTL and testbench
====================================

// Module: gray_code_counter
// PURPOSE
// - Registered, parametrised up/down Gray-code counter with parallel load and wrap flag.
// - Also synchronises and decodes a remote Gray pointer into this clock domain.
// - Building block for async-FIFO read/write pointers and CDC-safe counters in the switch datapath.
// - gray_count is a flop output and changes exactly one bit per inc/dec step.
// PARAMETERS
// - WIDTH        8   counter, pointer and load width in bits (>=2)
// - RESET_VALUE  0   binary value loaded on reset; must be < 2**WIDTH
// - SYNC_STAGES  2   flop stages on remote_gray_in (>=2; elaboration error if less)
// PORTS
// - clock           in   1      single clock; all flops rise-edge
// - reset           in   1      asynchronous, active-low reset
// - increment       in   1      count up by one this cycle
// - decrement       in   1      count down by one this cycle
// - load            in   1      load load_value (highest priority)
// - load_value      in   WIDTH  binary value for load
// - binary_count    out  WIDTH  registered binary count
// - gray_count      out  WIDTH  registered Gray encoding of binary_count
// - wrap            out  1      1-cycle pulse: count wrapped on last step
// - remote_gray_in  in   WIDTH  Gray pointer from another domain (async to clock)
// - remote_gray     out  WIDTH  remote pointer after SYNC_STAGES flops
// - remote_binary   out  WIDTH  registered binary decode of remote_gray
// BEHAVIOUR
// - Reset (reset==0, async, no clock edge needed):
//   - binary_count=RESET_VALUE, gray_count=RESET_VALUE^(RESET_VALUE>>1), wrap=0.
//   - All sync flops, remote_gray and remote_binary = 0.
// - Release is sampled on the next rising edge; no outputs change between reset deassertion and that edge.
// - Operation select per edge, priority order:
//   - load -> OP_LOAD
//   - increment^decrement -> OP_INC/OP_DEC
//   - else (incl. increment&decrement both 1) -> OP_HOLD
// - Latency: binary_count and gray_count reflect the op one cycle after it is sampled.
// - Both outputs update on the same edge; gray_count is registered from enc(next_binary), never combinationally derived.
// - Arithmetic is modulo 2**WIDTH:
//   - INC at all-ones -> 0
//   - DEC at 0 -> all-ones
// - wrap:
//   - Asserted for exactly the cycle following a modulo wrap.
//   - Never asserted on LOAD or HOLD, even when load_value crosses the boundary.
//   - Deasserts on the next edge unless another wrap occurs (back-to-back INC over successive wraps is impossible for WIDTH>=2).
// - Remote path:
//   - remote_gray_in passes through a SYNC_STAGES flop chain; last stage = remote_gray.
//   - remote_binary = gray2bin(remote_gray), registered one more stage.
//   - Total latency from a stable remote_gray_in to remote_binary is SYNC_STAGES+1 edges.
//   - No handshake; the input is expected to change by at most one bit per source step.
// - Remote path is independent of the local ops; load/inc/dec never affect it.
// - Reset mid-operation aborts any op immediately; a pending load is lost.
// STRUCTURE
// - gray_code_pkg:
//   - typedef enum logic [1:0] count_op_e {OP_HOLD, OP_INC, OP_DEC, OP_LOAD}
//   - localparam GRAY_MIN_SYNC_STAGES = 2
// - Encode: reuse existing gray_code_encode (WIDTH) on next_binary.
// - Decode: one new sub-module gray_code_decode #(WIDTH) (XOR-prefix from MSB), combinational.
//   - Instantiated on remote_gray; gets its own exhaustive bench.
// - Sync chain: packed array [SYNC_STAGES][WIDTH], marked with ASYNC_REG attribute.
// TESTING (WIDTH=4 unless noted, RESET_VALUE=0, SYNC_STAGES=2)
// - Up-count exhaustive:
//   - Stimulus: increment=1 for 20 cycles.
//   - binary 0..15,0..3; each step popcount(gray_prev^gray)==1.
//   - wrap=1 only in the cycle where binary_count==0 after 15.
// - Down-count:
//   - Stimulus: decrement=1 from 0.
//   - binary=15, gray=4'b1000, wrap=1 next cycle; then 14, gray=4'b1001, wrap=0.
// - Load priority (WIDTH=8):
//   - Stimulus: load=1, load_value=8'hA5, increment=1.
//   - Next cycle binary=8'hA5, gray=8'hF7, wrap=0.
// - Simultaneous inc&dec at count 7:
//   - Count stays 7 / gray 4'b0100 for all such cycles; wrap=0.
// - Remote sync:
//   - Stimulus: remote_gray_in 0->4'b1100 at edge N.
//   - remote_gray=4'b1100 after edge N+2; remote_binary=4'b1000 after edge N+3, not earlier.
// - Async reset mid-count:
//   - Stimulus: reset low between edges at count 9.
//   - binary=0, gray=0, wrap=0, remote regs 0 before next edge.
//   - After release, the first increment gives 1.

Source files
------------

// File: rtl/gray_code_pkg.sv
// Shared op encoding and limits for the Gray-code counter slice.
// No logic, so no latency and no backpressure.
package gray_code_pkg;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_INC,
    OP_DEC,
    OP_LOAD
  } count_op_e;

  localparam int GRAY_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/gray_code_counter_if.sv
// Control, count and remote-pointer signals of gray_code_counter; i_/o_ seen from the counter.
// No flow control: each signal is sampled or driven on every clock.
interface gray_code_counter_if #(
  parameter int WIDTH = 8
);

  logic             i_increment;
  logic             i_decrement;
  logic             i_load;
  logic [WIDTH-1:0] i_load_value;
  logic [WIDTH-1:0] i_remote_gray_in;
  logic [WIDTH-1:0] o_binary_count;
  logic [WIDTH-1:0] o_gray_count;
  logic             o_wrap;
  logic [WIDTH-1:0] o_remote_gray;
  logic [WIDTH-1:0] o_remote_binary;

  modport master (
    output i_increment, i_decrement, i_load, i_load_value, i_remote_gray_in,
    input  o_binary_count, o_gray_count, o_wrap, o_remote_gray, o_remote_binary
  );

  modport slave (
    input  i_increment, i_decrement, i_load, i_load_value, i_remote_gray_in,
    output o_binary_count, o_gray_count, o_wrap, o_remote_gray, o_remote_binary
  );

endinterface

// File: rtl/gray_code_decode.sv
// Gray to binary decoder as an XOR prefix from the MSB down; combinational, no backpressure.
module gray_code_decode #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_binary
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_binary[i] = ^i_gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_code_encode.sv
// Binary to Gray encoder; combinational, no backpressure.
module gray_code_encode #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_binary,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_binary ^ (i_binary >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// Up/down Gray counter with load and wrap pulse (1 cycle), plus remote Gray pointer
// synchroniser/decoder (SYNC_STAGES+1 cycles). No backpressure: every edge acts.
module gray_code_counter
  import gray_code_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int RESET_VALUE = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  gray_code_counter_if.slave   bus
);

  if (SYNC_STAGES < GRAY_MIN_SYNC_STAGES) begin : g_bad_sync
    $error("gray_code_counter: SYNC_STAGES must be at least 2");
  end

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  count_op_e        w_op;
  logic [WIDTH-1:0] w_next_binary;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_wrap;
  logic [WIDTH-1:0] w_remote_binary;

  logic [WIDTH-1:0] r_binary;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_remote_binary;

  // Load beats everything; inc and dec together cancel to a hold.
  always_comb begin
    w_op = OP_HOLD;
    if (bus.i_load) begin
      w_op = OP_LOAD;
    end else if (bus.i_increment ^ bus.i_decrement) begin
      w_op = bus.i_increment ? OP_INC : OP_DEC;
    end
  end

  always_comb begin
    w_next_binary = r_binary;
    w_next_wrap   = 1'b0;
    case (w_op)
      OP_INC: begin
        w_next_binary = r_binary + WIDTH'(1);
        w_next_wrap   = &r_binary;
      end
      OP_DEC: begin
        w_next_binary = r_binary - WIDTH'(1);
        w_next_wrap   = ~|r_binary;
      end
      OP_LOAD: w_next_binary = bus.i_load_value;
      default: w_next_binary = r_binary;
    endcase
  end

  gray_code_encode #(.WIDTH(WIDTH)) u_encode (
    .i_binary (w_next_binary),
    .o_gray   (w_next_gray)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_binary <= RST_BIN;
      r_gray   <= RST_GRAY;
      r_wrap   <= 1'b0;
    end else begin
      r_binary <= w_next_binary;
      r_gray   <= w_next_gray;
      r_wrap   <= w_next_wrap;
    end
  end

  // Stage 0 takes the asynchronous input; the last stage is the usable pointer.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_remote_gray_in};
    end
  end

  gray_code_decode #(.WIDTH(WIDTH)) u_decode (
    .i_gray   (r_sync[SYNC_STAGES-1]),
    .o_binary (w_remote_binary)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_remote_binary <= '0;
    end else begin
      r_remote_binary <= w_remote_binary;
    end
  end

  assign bus.o_binary_count  = r_binary;
  assign bus.o_gray_count    = r_gray;
  assign bus.o_wrap          = r_wrap;
  assign bus.o_remote_gray   = r_sync[SYNC_STAGES-1];
  assign bus.o_remote_binary = r_remote_binary;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench: 4-bit counter for counting/remote/reset cases, 8-bit counter for load priority.
module tb_gray_code_counter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  gray_code_counter_if #(.WIDTH(4)) bus4 ();
  gray_code_counter_if #(.WIDTH(8)) bus8 ();

  gray_code_counter #(.WIDTH(4), .RESET_VALUE(0), .SYNC_STAGES(2)) u_dut4 (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus4.slave)
  );

  gray_code_counter #(.WIDTH(8), .RESET_VALUE(0), .SYNC_STAGES(2)) u_dut8 (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus8.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic inc, input logic dec, input logic ld, input logic [3:0] val);
    bus4.i_increment  = inc;
    bus4.i_decrement  = dec;
    bus4.i_load       = ld;
    bus4.i_load_value = val;
  endtask

  task automatic check4(input string tag, input logic [3:0] b, input logic [3:0] g, input logic w);
    check({tag, "_bin"},  32'(bus4.o_binary_count), 32'(b));
    check({tag, "_gray"}, 32'(bus4.o_gray_count),   32'(g));
    check({tag, "_wrap"}, 32'(bus4.o_wrap),         32'(w));
  endtask

  logic [3:0] prev_gray;
  logic [3:0] exp_bin;

  initial begin
    rst_n = 1'b0;
    drive4(1'b0, 1'b0, 1'b0, 4'h0);
    bus4.i_remote_gray_in = 4'h0;
    bus8.i_increment      = 1'b0;
    bus8.i_decrement      = 1'b0;
    bus8.i_load           = 1'b0;
    bus8.i_load_value     = 8'h00;
    bus8.i_remote_gray_in = 8'h00;

    #3;
    check4("rst", 4'h0, 4'h0, 1'b0);
    check("rst_rgray", 32'(bus4.o_remote_gray), 32'h0);
    check("rst_rbin",  32'(bus4.o_remote_binary), 32'h0);
    check("rst_bin8",  32'(bus8.o_binary_count), 32'h0);

    #9 rst_n = 1'b1;
    step();
    check4("idle", 4'h0, 4'h0, 1'b0);

    // Up-count through one full wrap and four more.
    drive4(1'b1, 1'b0, 1'b0, 4'h0);
    prev_gray = 4'h0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_bin = 4'(k % 16);
      check4($sformatf("up%0d", k), exp_bin, exp_bin ^ (exp_bin >> 1), (k == 16));
      check($sformatf("up%0d_onebit", k), $countones(prev_gray ^ bus4.o_gray_count), 32'd1);
      prev_gray = bus4.o_gray_count;
    end

    drive4(1'b0, 1'b0, 1'b1, 4'h0);
    step();
    check4("ld0", 4'h0, 4'h0, 1'b0);

    drive4(1'b0, 1'b1, 1'b0, 4'h0);
    step();
    check4("dn1", 4'hF, 4'b1000, 1'b1);
    step();
    check4("dn2", 4'hE, 4'b1001, 1'b0);

    drive4(1'b0, 1'b0, 1'b1, 4'h7);
    step();
    check4("ld7", 4'h7, 4'b0100, 1'b0);
    drive4(1'b1, 1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check4($sformatf("both%0d", k), 4'h7, 4'b0100, 1'b0);
    end

    // Loads across the boundary never raise wrap.
    drive4(1'b0, 1'b0, 1'b1, 4'hF);
    step();
    check4("ldF", 4'hF, 4'b1000, 1'b0);
    drive4(1'b1, 1'b0, 1'b1, 4'h0);
    step();
    check4("ldF0", 4'h0, 4'h0, 1'b0);
    drive4(1'b0, 1'b1, 1'b1, 4'hA);
    step();
    check4("ldA_dec", 4'hA, 4'b1111, 1'b0);

    bus8.i_load       = 1'b1;
    bus8.i_load_value = 8'hA5;
    bus8.i_increment  = 1'b1;
    step();
    check("ld8_bin",  32'(bus8.o_binary_count), 32'hA5);
    check("ld8_gray", 32'(bus8.o_gray_count),   32'hF7);
    check("ld8_wrap", 32'(bus8.o_wrap),         32'h0);
    bus8.i_load      = 1'b0;
    bus8.i_increment = 1'b0;

    // Remote pointer changes right after edge N; local inc runs alongside.
    drive4(1'b1, 1'b0, 1'b0, 4'h0);
    bus4.i_remote_gray_in = 4'b1100;
    step();
    check("rs1_gray", 32'(bus4.o_remote_gray),   32'h0);
    check("rs1_bin",  32'(bus4.o_remote_binary), 32'h0);
    step();
    check("rs2_gray", 32'(bus4.o_remote_gray),   32'hC);
    check("rs2_bin",  32'(bus4.o_remote_binary), 32'h0);
    step();
    check("rs3_gray", 32'(bus4.o_remote_gray),   32'hC);
    check("rs3_bin",  32'(bus4.o_remote_binary), 32'h8);
    check("rs3_local", 32'(bus4.o_binary_count), 32'hD);

    bus4.i_remote_gray_in = 4'b1101;
    step();
    step();
    step();
    check("rs4_bin", 32'(bus4.o_remote_binary), 32'h9);

    drive4(1'b0, 1'b0, 1'b1, 4'h9);
    step();
    check4("ld9", 4'h9, 4'b1101, 1'b0);

    // Reset between edges with a load pending.
    drive4(1'b0, 1'b0, 1'b1, 4'h5);
    #3 rst_n = 1'b0;
    #1;
    check4("arst", 4'h0, 4'h0, 1'b0);
    check("arst_rgray", 32'(bus4.o_remote_gray),   32'h0);
    check("arst_rbin",  32'(bus4.o_remote_binary), 32'h0);
    drive4(1'b1, 1'b0, 1'b0, 4'h0);
    #2 rst_n = 1'b1;
    #1;
    check4("rel", 4'h0, 4'h0, 1'b0);
    step();
    check4("rel_inc", 4'h1, 4'b0001, 1'b0);
    check("rel_rgray", 32'(bus4.o_remote_gray), 32'h0);

    drive4(1'b0, 1'b0, 1'b0, 4'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
